dec_iq_stage: RTL and testbench

DEC_IQ_STAGE -- requirements
Module: dec_iq_stage

---
 rtl/dec_iq_stage.sv | 221 ++++++++++++++++++++++
 tb/tb_dec_iq_stage.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dec_iq_stage.sv
// Decode / issue stage: circular instruction queue feeding a registered execute slot,
// with operand selection, load-use interlock and branch resolution against the fetch prediction.
module dec_iq_stage #(
    parameter int IQ_DEPTH = 4,
    parameter int BP_CHECK = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        fe_valid,
    output logic                        fe_ready,
    input  logic [31:0]                 fe_pc,
    input  logic [31:0]                 fe_ir,
    input  logic                        fe_rv16,
    input  logic                        fe_pred_taken,
    output logic [4:0]                  rs1_addr,
    output logic [4:0]                  rs2_addr,
    input  logic [31:0]                 rs1v,
    input  logic [31:0]                 rs2v,
    input  logic                        flush,
    input  logic                        ex_ready,
    output logic                        ex_valid,
    output logic [31:0]                 ex_pc,
    output logic [31:0]                 ex_op1,
    output logic [31:0]                 ex_op2,
    output logic [2:0]                  ex_aluop,
    output logic [6:0]                  ex_aluop_sub,
    output logic [2:0]                  ex_mem_op,
    output logic                        ex_wr_reg,
    output logic [4:0]                  ex_rd,
    output logic                        ex_load,
    output logic                        ex_store,
    output logic                        ex_illegal,
    output logic [31:0]                 ex_wdata,
    output logic                        redirect,
    output logic [31:0]                 redirect_pc,
    output logic [$clog2(IQ_DEPTH):0]   iq_count
);
    localparam int PW = $clog2(IQ_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
    localparam logic [6:0] OPC_IMM     = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
        logic        rv16;
        logic        pred;
    } iq_entry_t;

    iq_entry_t       iq_mem [IQ_DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;

    iq_entry_t       head;
    logic [31:0]     ir, i_imm, s_imm, b_imm, u_imm, link_inc, br_target;
    logic [2:0]      f3;
    logic            has_head, push, issue, stall, kill_q, mispredict, taken, pred_eff;
    logic            use_rs1, use_rs2, is_branch;
    logic [31:0]     d_op1, d_op2, d_wdata;
    logic [2:0]      d_aluop;
    logic [6:0]      d_sub;
    logic            d_wr, d_load, d_store, d_ill;

    assign head     = iq_mem[rd_ptr];
    assign ir       = head.ir;
    assign f3       = ir[14:12];
    assign has_head = (count != '0);
    assign iq_count = count;
    assign fe_ready = (count < CW'(IQ_DEPTH));
    assign rs1_addr = has_head ? ir[19:15] : 5'd0;
    assign rs2_addr = has_head ? ir[24:20] : 5'd0;

    assign i_imm    = {{20{ir[31]}}, ir[31:20]};
    assign s_imm    = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign b_imm    = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign u_imm    = {ir[31:12], 12'd0};
    assign link_inc = head.rv16 ? 32'd2 : 32'd4;

    // NOTE: every signal assigned in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        d_op1     = '0;
        d_op2     = '0;
        d_wdata   = '0;
        d_aluop   = '0;
        d_sub     = '0;
        d_wr      = 1'b0;
        d_load    = 1'b0;
        d_store   = 1'b0;
        d_ill     = 1'b0;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        is_branch = 1'b0;
        case (ir[6:0])
            OPC_LOAD:    begin d_op1 = rs1v; d_op2 = i_imm; d_wr = 1'b1; d_load = 1'b1; use_rs1 = 1'b1; end
            OPC_IMM: begin
                d_op1   = rs1v;
                d_op2   = i_imm;
                d_aluop = f3;
                d_sub   = (f3 == 3'd1 || f3 == 3'd5) ? ir[31:25] : 7'd1;
                d_wr    = 1'b1;
                use_rs1 = 1'b1;
            end
            OPC_OP: begin
                d_op1   = rs1v;
                d_op2   = rs2v;
                d_aluop = f3;
                d_sub   = ir[31:25];
                d_wr    = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OPC_STORE:   begin d_op1 = rs1v; d_op2 = s_imm; d_wdata = rs2v; d_store = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OPC_LUI:     begin d_op1 = u_imm; d_wr = 1'b1; end
            OPC_AUIPC:   begin d_op1 = u_imm; d_op2 = head.pc; d_wr = 1'b1; end
            OPC_JAL:     begin d_op1 = head.pc; d_op2 = link_inc; d_wr = 1'b1; end
            OPC_JALR:    begin d_op1 = head.pc; d_op2 = link_inc; d_wr = 1'b1; use_rs1 = 1'b1; end
            OPC_BRANCH:  begin d_op1 = rs1v; d_op2 = rs2v; is_branch = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OPC_MISCMEM: ;
            default:     d_ill = 1'b1;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (f3)
            3'b000:  taken = (rs1v == rs2v);
            3'b001:  taken = (rs1v != rs2v);
            3'b100:  taken = ($signed(rs1v) <  $signed(rs2v));
            3'b101:  taken = ($signed(rs1v) >= $signed(rs2v));
            3'b110:  taken = (rs1v <  rs2v);
            3'b111:  taken = (rs1v >= rs2v);
            default: taken = 1'b0;
        endcase
    end

    assign br_target  = head.pc + (taken ? b_imm : link_inc);
    assign pred_eff   = (BP_CHECK != 0) ? head.pred : 1'b0;
    assign stall      = ex_valid && ex_load && (ex_rd != 5'd0) &&
                        ((use_rs1 && ir[19:15] == ex_rd) || (use_rs2 && ir[24:20] == ex_rd));
    assign issue      = has_head && !stall && !flush && (!ex_valid || ex_ready);
    assign mispredict = issue && is_branch && (taken != pred_eff);
    assign push       = fe_valid && fe_ready;
    assign kill_q     = flush || mispredict;

    // NOTE: queue storage carries no reset; occupancy is governed entirely by the pointers and count.
    always_ff @(posedge clk) begin
        if (push && !kill_q) iq_mem[wr_ptr] <= '{pc: fe_pc, ir: fe_ir, rv16: fe_rv16, pred: fe_pred_taken};
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (kill_q) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)  wr_ptr <= wr_ptr + PW'(1);
            if (issue) rd_ptr <= rd_ptr + PW'(1);
            case ({push, issue})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid     <= 1'b0;
            ex_pc        <= '0;
            ex_op1       <= '0;
            ex_op2       <= '0;
            ex_aluop     <= '0;
            ex_aluop_sub <= '0;
            ex_mem_op    <= '0;
            ex_wr_reg    <= 1'b0;
            ex_rd        <= '0;
            ex_load      <= 1'b0;
            ex_store     <= 1'b0;
            ex_illegal   <= 1'b0;
            ex_wdata     <= '0;
            redirect     <= 1'b0;
            redirect_pc  <= '0;
        end else begin
            redirect <= mispredict;
            if (mispredict) redirect_pc <= br_target;
            if (flush) begin
                ex_valid <= 1'b0;
            end else if (issue) begin
                ex_valid     <= 1'b1;
                ex_pc        <= head.pc;
                ex_op1       <= d_op1;
                ex_op2       <= d_op2;
                ex_aluop     <= d_aluop;
                ex_aluop_sub <= d_sub;
                ex_mem_op    <= f3;
                ex_wr_reg    <= d_wr;
                ex_rd        <= ir[11:7];
                ex_load      <= d_load;
                ex_store     <= d_store;
                ex_illegal   <= d_ill;
                ex_wdata     <= d_wdata;
            end else if (ex_ready) begin
                ex_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_dec_iq_stage.sv
// Directed bench for dec_iq_stage: a decode/branch vector table plus hand sequences for
// queue fill, load-use bubble, mispredict, flush priority and mid-operation reset.
module tb_dec_iq_stage;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [31:0] NOP       = 32'h0000_0013;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        fe_valid, fe_ready, fe_rv16, fe_pred_taken, flush, ex_ready;
    logic [31:0] fe_pc, fe_ir, rs1v, rs2v;
    logic [4:0]  rs1_addr, rs2_addr, ex_rd;
    logic        ex_valid, ex_wr_reg, ex_load, ex_store, ex_illegal, redirect;
    logic [31:0] ex_pc, ex_op1, ex_op2, ex_wdata, redirect_pc;
    logic [2:0]  ex_aluop, ex_mem_op, iq_count;
    logic [6:0]  ex_aluop_sub;

    int checks = 0;
    int errors = 0;

    dec_iq_stage #(.IQ_DEPTH(4), .BP_CHECK(1)) dut (
        .clk(clk), .rst_n(rst_n), .fe_valid(fe_valid), .fe_ready(fe_ready), .fe_pc(fe_pc), .fe_ir(fe_ir),
        .fe_rv16(fe_rv16), .fe_pred_taken(fe_pred_taken), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1v(rs1v), .rs2v(rs2v), .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_aluop(ex_aluop), .ex_aluop_sub(ex_aluop_sub),
        .ex_mem_op(ex_mem_op), .ex_wr_reg(ex_wr_reg), .ex_rd(ex_rd), .ex_load(ex_load), .ex_store(ex_store),
        .ex_illegal(ex_illegal), .ex_wdata(ex_wdata), .redirect(redirect), .redirect_pc(redirect_pc),
        .iq_count(iq_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc, ir;
        logic        rv16, pred;
        logic [31:0] rs1v, rs2v;
        logic [2:0]  chk;      // {operands, alu controls, memory controls}
        logic [31:0] op1, op2;
        logic [2:0]  aluop;
        logic [6:0]  sub;
        logic [2:0]  mem;
        logic [4:0]  flags;    // {wr_reg, load, store, illegal, redirect}
        logic [31:0] rpc;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3, logic [4:0] rd, logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3, logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OPC_OP};
    endfunction
    function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
    endfunction
    function automatic logic [31:0] enc_b(logic [12:0] imm, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_u(logic [19:0] imm, logic [4:0] rd, logic [6:0] op);
        return {imm, rd, op};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        fe_valid = 1'b0; fe_rv16 = 1'b0; fe_pred_taken = 1'b0; flush = 1'b0; ex_ready = 1'b1;
        fe_ir = NOP; fe_pc = '0; rs1v = '0; rs2v = '0;
        step();
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] ir, input logic pred);
        fe_valid = 1'b1; fe_pc = pc; fe_ir = ir; fe_pred_taken = pred;
        step();
    endtask

    initial begin
        vecs[0]  = '{32'h100, enc_i(12'hFFB, 5'd1, 3'd0, 5'd3, OPC_IMM), 1'b0, 1'b0, 32'd10, 32'd0, 3'b110, 32'd10, 32'hFFFF_FFFB, 3'd0, 7'd1, 3'd0, 5'b10000, 32'd0};
        vecs[1]  = '{32'h100, enc_i(12'h404, 5'd1, 3'd5, 5'd3, OPC_IMM), 1'b0, 1'b0, 32'h8000_0000, 32'd0, 3'b110, 32'h8000_0000, 32'h404, 3'd5, 7'h20, 3'd0, 5'b10000, 32'd0};
        vecs[2]  = '{32'h100, enc_r(7'h20, 5'd2, 5'd5, 3'd0, 5'd6), 1'b0, 1'b0, 32'd9, 32'd3, 3'b110, 32'd9, 32'd3, 3'd0, 7'h20, 3'd0, 5'b10000, 32'd0};
        vecs[3]  = '{32'h100, enc_s(12'hFFC, 5'd2, 5'd1, 3'd2), 1'b0, 1'b0, 32'h1000, 32'hDEAD_BEEF, 3'b101, 32'h1000, 32'hFFFF_FFFC, 3'd0, 7'd0, 3'd2, 5'b00100, 32'd0};
        vecs[4]  = '{32'h100, enc_i(12'h008, 5'd1, 3'd2, 5'd5, OPC_LOAD), 1'b0, 1'b0, 32'h2000, 32'd0, 3'b101, 32'h2000, 32'd8, 3'd0, 7'd0, 3'd2, 5'b11000, 32'd0};
        vecs[5]  = '{32'h100, enc_u(20'h12345, 5'd7, OPC_LUI), 1'b0, 1'b0, 32'd0, 32'd0, 3'b100, 32'h1234_5000, 32'd0, 3'd0, 7'd0, 3'd0, 5'b10000, 32'd0};
        vecs[6]  = '{32'h100, enc_u(20'h00001, 5'd7, OPC_AUIPC), 1'b0, 1'b0, 32'd0, 32'd0, 3'b100, 32'h1000, 32'h100, 3'd0, 7'd0, 3'd0, 5'b10000, 32'd0};
        vecs[7]  = '{32'h300, 32'h0080_00EF, 1'b1, 1'b0, 32'd0, 32'd0, 3'b100, 32'h300, 32'd2, 3'd0, 7'd0, 3'd0, 5'b10000, 32'd0};
        vecs[8]  = '{32'h300, enc_i(12'h000, 5'd2, 3'd0, 5'd1, OPC_JALR), 1'b0, 1'b0, 32'd0, 32'd0, 3'b100, 32'h300, 32'd4, 3'd0, 7'd0, 3'd0, 5'b10000, 32'd0};
        vecs[9]  = '{32'h100, 32'h0000_000F, 1'b0, 1'b0, 32'd0, 32'd0, 3'b000, 32'd0, 32'd0, 3'd0, 7'd0, 3'd0, 5'b00000, 32'd0};
        vecs[10] = '{32'h100, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, 32'd0, 3'b000, 32'd0, 32'd0, 3'd0, 7'd0, 3'd0, 5'b00010, 32'd0};
        vecs[11] = '{32'h100, enc_b(13'd16, 5'd2, 5'd1, 3'd0), 1'b0, 1'b0, 32'd7, 32'd7, 3'b000, 32'd0, 32'd0, 3'd0, 7'd0, 3'd0, 5'b00001, 32'h110};
        vecs[12] = '{32'h200, enc_b(13'd16, 5'd2, 5'd1, 3'd5), 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, 3'b000, 32'd0, 32'd0, 3'd0, 7'd0, 3'd0, 5'b00001, 32'h204};
        vecs[13] = '{32'h200, enc_b(13'd16, 5'd2, 5'd1, 3'd7), 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, 3'b000, 32'd0, 32'd0, 3'd0, 7'd0, 3'd0, 5'b00000, 32'd0};
        vecs[14] = '{32'h100, enc_b(13'h1FF8, 5'd2, 5'd1, 3'd4), 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd1, 3'b000, 32'd0, 32'd0, 3'd0, 7'd0, 3'd0, 5'b00001, 32'h0F8};
        vecs[15] = '{32'hFFFF_FFFE, enc_b(13'd16, 5'd2, 5'd1, 3'd1), 1'b1, 1'b1, 32'd5, 32'd5, 3'b000, 32'd0, 32'd0, 3'd0, 7'd0, 3'd0, 5'b00001, 32'h0};
        vecs[16] = '{32'h100, enc_b(13'd16, 5'd2, 5'd1, 3'd6), 1'b0, 1'b1, 32'd1, 32'hFFFF_FFFF, 3'b000, 32'd0, 32'd0, 3'd0, 7'd0, 3'd0, 5'b00000, 32'd0};
        vecs[17] = '{32'h100, enc_b(13'd16, 5'd2, 5'd1, 3'd5), 1'b0, 1'b0, 32'd5, 32'd5, 3'b000, 32'd0, 32'd0, 3'd0, 7'd0, 3'd0, 5'b00001, 32'h110};

        fe_valid = 1'b0; fe_rv16 = 1'b0; fe_pred_taken = 1'b0; flush = 1'b0; ex_ready = 1'b1;
        fe_ir = NOP; fe_pc = '0; rs1v = '0; rs2v = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset fe_ready", fe_ready, 1);
        check("reset iq_count", iq_count, 0);
        check("reset ex_valid", ex_valid, 0);
        check("reset redirect", redirect, 0);
        rst_n = 1'b1;
        step();

        // Decode and branch vectors: push one entry, let it issue, compare the issue slot.
        for (int i = 0; i < NV; i++) begin
            fe_valid = 1'b1; fe_pc = vecs[i].pc; fe_ir = vecs[i].ir; fe_rv16 = vecs[i].rv16;
            fe_pred_taken = vecs[i].pred; rs1v = vecs[i].rs1v; rs2v = vecs[i].rs2v;
            step();
            fe_valid = 1'b0;
            step();
            check($sformatf("v%0d ex_valid", i), ex_valid, 1);
            check($sformatf("v%0d ex_pc", i), ex_pc, vecs[i].pc);
            check($sformatf("v%0d flags", i), {ex_wr_reg, ex_load, ex_store, ex_illegal, redirect}, vecs[i].flags);
            if (vecs[i].chk[2]) begin
                check($sformatf("v%0d op1", i), ex_op1, vecs[i].op1);
                check($sformatf("v%0d op2", i), ex_op2, vecs[i].op2);
            end
            if (vecs[i].chk[1]) begin
                check($sformatf("v%0d aluop", i), ex_aluop, vecs[i].aluop);
                check($sformatf("v%0d aluop_sub", i), ex_aluop_sub, vecs[i].sub);
            end
            if (vecs[i].chk[0]) check($sformatf("v%0d mem_op", i), ex_mem_op, vecs[i].mem);
            if (vecs[i].flags[2]) check($sformatf("v%0d wdata", i), ex_wdata, vecs[i].rs2v);
            if (vecs[i].flags[4]) check($sformatf("v%0d rd", i), ex_rd, vecs[i].ir[11:7]);
            if (vecs[i].flags[0]) check($sformatf("v%0d redirect_pc", i), redirect_pc, vecs[i].rpc);
        end

        // Fill with the execute slot stalled, then release it while fetch still pushes.
        idle();
        ex_ready = 1'b0;
        for (int k = 0; k < 5; k++) push(32'h400 + 32'(4 * k), NOP, 1'b0);
        check("fill iq_count", iq_count, 4);
        check("fill fe_ready", fe_ready, 0);
        check("fill ex_valid", ex_valid, 1);
        check("fill ex_pc", ex_pc, 32'h400);
        ex_ready = 1'b1; fe_pc = 32'h414;
        step();
        check("full pop no push", iq_count, 3);
        check("drain ex_pc 1", ex_pc, 32'h404);
        fe_valid = 1'b0;
        for (int k = 2; k <= 4; k++) begin
            step();
            check($sformatf("drain ex_pc %0d", k), ex_pc, 32'h400 + 32'(4 * k));
            check($sformatf("drain count %0d", k), iq_count, 32'(4 - k));
        end
        step();
        check("drain ex_valid", ex_valid, 0);

        // Load-use: lw x5,0(x1) followed by add x6,x5,x2.
        idle();
        push(32'h500, 32'h0000_A283, 1'b0);
        push(32'h504, 32'h0022_8333, 1'b0);
        fe_valid = 1'b0;
        check("lu lw issued", {ex_valid, ex_load}, 2'b11);
        check("lu rs1_addr", rs1_addr, 5);
        step();
        check("lu bubble ex_valid", ex_valid, 0);
        check("lu bubble count", iq_count, 1);
        step();
        check("lu add ex_valid", ex_valid, 1);
        check("lu add ex_pc", ex_pc, 32'h504);
        check("lu add ex_rd", ex_rd, 6);

        // Mispredict with younger entries queued and a push on the resolving cycle.
        idle();
        ex_ready = 1'b0; rs1v = 32'd7; rs2v = 32'd7;
        push(32'h0F0, NOP, 1'b0);
        push(32'h100, 32'h0020_8863, 1'b0);
        push(32'h104, NOP, 1'b0);
        push(32'h108, NOP, 1'b0);
        check("mp queued", iq_count, 3);
        ex_ready = 1'b1; fe_pc = 32'h10C;
        step();
        fe_valid = 1'b0;
        check("mp redirect", redirect, 1);
        check("mp redirect_pc", redirect_pc, 32'h110);
        check("mp iq_count", iq_count, 0);
        check("mp ex_pc", ex_pc, 32'h100);
        step();
        check("mp redirect pulse", redirect, 0);
        check("mp ex_valid after", ex_valid, 0);

        // Flush with three entries queued and a same-cycle push.
        idle();
        ex_ready = 1'b0;
        for (int k = 0; k < 4; k++) push(32'h600 + 32'(4 * k), NOP, 1'b0);
        check("fl queued", iq_count, 3);
        flush = 1'b1; fe_pc = 32'h610;
        step();
        flush = 1'b0; fe_valid = 1'b0;
        check("fl iq_count", iq_count, 0);
        check("fl ex_valid", ex_valid, 0);
        step();
        check("fl dropped push", iq_count, 0);

        // Flush wins over a mispredicting branch at the head.
        idle();
        rs1v = 32'd7; rs2v = 32'd7;
        push(32'h100, 32'h0020_8863, 1'b0);
        fe_valid = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        check("fl-br redirect", redirect, 0);
        check("fl-br ex_valid", ex_valid, 0);
        check("fl-br iq_count", iq_count, 0);

        // Reset asserted in the middle of a load-use stall.
        idle();
        ex_ready = 1'b0;
        push(32'h700, 32'h0000_A283, 1'b0);
        push(32'h704, 32'h0022_8333, 1'b0);
        fe_valid = 1'b0;
        check("rst pre stall", {ex_valid, ex_load, iq_count}, {2'b11, 3'd1});
        rst_n = 1'b0;
        #1;
        check("rst ex_valid", ex_valid, 0);
        check("rst ex_load", ex_load, 0);
        check("rst ex_pc", ex_pc, 0);
        check("rst ex_rd", ex_rd, 0);
        check("rst iq_count", iq_count, 0);
        check("rst redirect_pc", redirect_pc, 0);
        check("rst rs1_addr", rs1_addr, 0);
        check("rst fe_ready", fe_ready, 1);
        step();
        rst_n = 1'b1; ex_ready = 1'b1;
        step();
        step();
        check("post-rst outputs", {ex_valid, redirect, iq_count}, 5'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
